// File: rtl/usb_rx_unstuff_sr.sv
// -----------------------------------------------------------------------------
// usb_rx_unstuff_sr
//
// Purpose:
//   Receive-path stage that follows the NRZI decoder in a USB full-speed
//   receiver. On each shift_enable strobe it takes one decoded bit, drops the
//   stuffed zero that follows every run of STUFF_LEN ones, and shifts the
//   remaining data bits LSB-first into a byte register. Each completed byte
//   is presented on rx_byte together with a one-cycle byte_ready pulse.
//
// Parameters:
//   DATA_WIDTH   bits per assembled byte (default 8)
//   STUFF_LEN    run length of ones after which a stuffed bit follows (default 6)
//
// Ports:
//   clk           in   system clock, rising-edge
//   rst           in   asynchronous active-high reset
//   d_orig        in   decoded bit from the NRZI decoder
//   shift_enable  in   one-cycle strobe qualifying d_orig
//   eop           in   end of packet, only meaningful with shift_enable
//   sync_clear    in   start-of-packet pulse, clears framing state
//   rx_byte       out  last completed byte, bit 0 = first received data bit
//   byte_ready    out  one-cycle pulse when rx_byte is updated
//   stuff_error   out  one-cycle pulse on a bit-stuff violation
//
// Build option:
//   USB_UNSTUFF_ERR_EN  when defined, a 1 received where a stuffed 0 was
//                       expected pulses stuff_error and aborts the current
//                       byte. When undefined, stuff_error is constant 0 and
//                       such a bit is silently dropped like a legal stuffed 0.
// -----------------------------------------------------------------------------
module usb_rx_unstuff_sr #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_LEN  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_orig,
  input  logic                  shift_enable,
  input  logic                  eop,
  input  logic                  sync_clear,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  byte_ready,
  output logic                  stuff_error
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [OW-1:0]         ones_cnt_q, ones_cnt_d;
  logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  stuff_error_q, stuff_error_d;

  // Shared helpers for a data bit accepted in DATA.
  logic [DATA_WIDTH-1:0] shifted;
  logic [OW-1:0]         ones_next;
  logic                  data_bit;

  assign shifted   = {d_orig, shift_q[DATA_WIDTH-1:1]};
  assign ones_next = d_orig ? (ones_cnt_q + 1'b1) : '0;
  // A strobe that is neither pre-empted by sync_clear nor by eop.
  assign data_bit  = shift_enable && !sync_clear && !eop;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (sync_clear || (shift_enable && eop)) begin
      state_d = ST_DATA;
    end else if (shift_enable) begin
      case (state_q)
        ST_DATA: if (ones_next == OW'(STUFF_LEN)) state_d = ST_SKIP;
        ST_SKIP: state_d = ST_DATA;
        default: state_d = ST_DATA;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    ones_cnt_d    = ones_cnt_q;
    rx_byte_d     = rx_byte_q;
    byte_ready_d  = 1'b0;
    stuff_error_d = 1'b0;

    if (sync_clear || (shift_enable && eop)) begin
      // Framing restart; shift_reg keeps its contents, a partial byte is lost.
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end else if (data_bit) begin
      if (state_q == ST_DATA) begin
        shift_d    = shifted;
        // Run counter deliberately survives byte completion so runs that
        // straddle a byte boundary are still detected.
        ones_cnt_d = ones_next;
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          bit_cnt_d    = '0;
          rx_byte_d    = shifted;
          byte_ready_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else begin
        // Stuffed position: never shifted, never counted.
        ones_cnt_d = '0;
`ifdef USB_UNSTUFF_ERR_EN
        if (d_orig) begin
          stuff_error_d = 1'b1;
          bit_cnt_d     = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ones_cnt_q    <= '0;
      rx_byte_q     <= '0;
      byte_ready_q  <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      ones_cnt_q    <= ones_cnt_d;
      rx_byte_q     <= rx_byte_d;
      byte_ready_q  <= byte_ready_d;
      stuff_error_q <= stuff_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_byte     = rx_byte_q;
    byte_ready  = byte_ready_q;
    stuff_error = stuff_error_q;
  end

endmodule

// File: tb/tb_usb_rx_unstuff_sr.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_unstuff_sr
//
// Directed stimulus for usb_rx_unstuff_sr. Each stimulus step that should
// produce a byte or a stuff error pushes the hand-computed expectation (value
// and the cycle it must appear in) into a queue; an independent monitor pops
// and compares whenever the DUT pulses byte_ready or stuff_error.
// -----------------------------------------------------------------------------
module tb_usb_rx_unstuff_sr;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic       sync_clear;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       stuff_error;

  usb_rx_unstuff_sr #(
    .DATA_WIDTH (8),
    .STUFF_LEN  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .eop          (eop),
    .sync_clear   (sync_clear),
    .rx_byte      (rx_byte),
    .byte_ready   (byte_ready),
    .stuff_error  (stuff_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t byte_q[$];
  int   err_q[$];
  exp_t e_b;
  int   e_at;

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_ready) begin
        tests++;
        if (byte_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte_ready got rx_byte=%h at cycle %0d, required none", rx_byte, cyc);
        end else begin
          e_b = byte_q.pop_front();
          if (rx_byte !== e_b.val) begin
            fails++;
            $display("FAIL rx_byte value got=%h required=%h", rx_byte, e_b.val);
          end
          tests++;
          if (cyc != e_b.at) begin
            fails++;
            $display("FAIL byte_ready timing got cycle %0d required cycle %0d", cyc, e_b.at);
          end
          $display("[TB] byte %h at cycle %0d", rx_byte, cyc);
        end
      end
      if (stuff_error) begin
        tests++;
        if (err_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_stuff_error at cycle %0d, required none", cyc);
        end else begin
          e_at = err_q.pop_front();
          if (cyc != e_at) begin
            fails++;
            $display("FAIL stuff_error timing got cycle %0d required cycle %0d", cyc, e_at);
          end
          $display("[TB] stuff_error at cycle %0d", cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs driven on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic strobe(input logic b, input logic e, input logic sc);
    @(negedge clk);
    d_orig       = b;
    shift_enable = 1'b1;
    eop          = e;
    sync_clear   = sc;
  endtask

  task automatic idle();
    @(negedge clk);
    shift_enable = 1'b0;
    eop          = 1'b0;
    sync_clear   = 1'b0;
    d_orig       = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    shift_enable = 1'b0;
    eop          = 1'b0;
    sync_clear   = 1'b1;
    idle();
  endtask

  // Sends n bits of 'bits', LSB first, on consecutive cycles.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) strobe(bits[i], 1'b0, 1'b0);
  endtask

  // Called in the same cycle as the strobe that completes the byte.
  task automatic exp_byte(input logic [7:0] v);
    exp_t x;
    x.val = v;
    x.at  = cyc + 1;
    byte_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("[TB] %s = %h ok", name, got);
    end
  endtask

  logic [7:0] v5a;

  initial begin
    rst          = 1'b1;
    d_orig       = 1'b0;
    shift_enable = 1'b0;
    eop          = 1'b0;
    sync_clear   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rx_byte",     rx_byte,            8'h00);
    check("reset_byte_ready",  {7'd0, byte_ready}, 8'h00);
    check("reset_stuff_error", {7'd0, stuff_error}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Plain byte, no runs: bits 0,0,1,1,0,1,0,1 -> 0xAC.
    send_bits(32'hAC, 8);
    exp_byte(8'hAC);
    idle();
    clr();

    // Six ones, stuffed 0, then 1,1 -> 0xFF after 9 strobes.
    send_bits(32'h3F, 6);
    strobe(1'b0, 1'b0, 1'b0);
    send_bits(32'h3, 2);
    exp_byte(8'hFF);
    idle();
    clr();

    // Run of six ones across the byte boundary, stuffed 0 in byte 1.
    send_bits(32'hE0, 8);
    exp_byte(8'hE0);
    send_bits(32'h7, 3);
    strobe(1'b0, 1'b0, 1'b0);
    send_bits(32'h0, 5);
    exp_byte(8'h07);
    idle();
    clr();

    // Bit-stuff violation: 0, six ones, then a 1 in the stuffed slot,
    // followed by the bits of 0x5A.
    strobe(1'b0, 1'b0, 1'b0);
    send_bits(32'h3F, 6);
    strobe(1'b1, 1'b0, 1'b0);
`ifdef USB_UNSTUFF_ERR_EN
    err_q.push_back(cyc + 1);
`endif
    v5a = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      strobe(v5a[i], 1'b0, 1'b0);
`ifdef USB_UNSTUFF_ERR_EN
      if (i == 7) exp_byte(8'h5A);
`else
      if (i == 0) exp_byte(8'h7E);
`endif
    end
    idle();
    clr();

    // EOP after a partial byte, sync_clear with a coincident strobe, then 0x3C.
    send_bits(32'h5, 4);
    strobe(1'b1, 1'b1, 1'b0);
    strobe(1'b1, 1'b0, 1'b1);
    send_bits(32'h3C, 8);
    exp_byte(8'h3C);
    idle();

    // Reset in the middle of a byte, then 0x81.
    send_bits(32'h1F, 5);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_byte",     rx_byte,             8'h00);
    check("midrst_byte_ready",  {7'd0, byte_ready},  8'h00);
    check("midrst_stuff_error", {7'd0, stuff_error}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send_bits(32'h81, 8);
    exp_byte(8'h81);
    idle();

    repeat (4) idle();
    check("pending_bytes",  8'(byte_q.size()), 8'h00);
    check("pending_errors", 8'(err_q.size()),  8'h00);
    check("final_rx_byte",  rx_byte,           8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
